// File: rtl/slinky_pkg.sv
// slinky_pkg: register offsets, step modes and bus phase numbers shared by the slinky pointer card
package slinky_pkg;
  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_INC  = 2'b01,
    MODE_DEC  = 2'b10
  } step_mode_e;
  localparam logic [1:0] OFF_LO   = 2'd0;
  localparam logic [1:0] OFF_MID  = 2'd1;
  localparam logic [1:0] OFF_HI   = 2'd2;
  localparam logic [1:0] OFF_DATA = 2'd3;
  localparam logic [3:0] REG_MODE = 4'hE;
  localparam logic [3:0] REG_BANK = 4'hF;
  localparam logic [2:0] S_SYNC    = 3'd1;
  localparam logic [2:0] S_RIP_MID = 3'd2;
  localparam logic [2:0] S_RIP_HI  = 3'd3;
  localparam logic [2:0] S_BUS     = 3'd4;
  localparam logic [2:0] S_CS      = 3'd5;
  localparam logic [2:0] S_WRITE   = 3'd6;
  localparam logic [2:0] S_LATE    = 3'd7;
endpackage

// File: rtl/slinky_ptr.sv
// slinky_ptr: one auto-stepping address pointer; byte writes, write-carry/borrow and a
// carry ripple staged one byte per bus phase (low at S1, mid at S2, high at S3).
module slinky_ptr
  import slinky_pkg::*;
#(
  parameter int ADDR_W = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [2:0]  s,
  input  logic [2:0]  wr_en,
  input  logic        step,
  input  logic [7:0]  din,
  input  logic [1:0]  mode,
  output logic [23:0] ptr
);
  localparam logic [23:0] MSK = 24'((33'd1 << ADDR_W) - 33'd1);
  localparam logic [2:0] STG [3] = '{S_SYNC, S_RIP_MID, S_RIP_HI};
  logic [23:0] ptr_q, ptr_d;
  logic [2:0]  pend_q, pend_d, dec_q, dec_d;
  logic        inc, dn;
  always_comb begin
    ptr_d  = ptr_q;
    pend_d = pend_q;
    dec_d  = dec_q;
    inc    = mode == MODE_INC;
    dn     = mode == MODE_DEC;
    if (s == S_WRITE) begin
      for (int b = 0; b < 3; b++)
        if (wr_en[b]) ptr_d[8*b +: 8] = din;
      // bit 7 falling (inc) or rising (dec) under a write means software crossed a byte boundary
      for (int b = 0; b < 2; b++)
        if (wr_en[b] && ((inc && ptr_q[8*b+7] && !din[7]) || (dn && !ptr_q[8*b+7] && din[7]))) begin
          pend_d[b+1] = 1'b1;
          dec_d[b+1]  = dn;
        end
      if (step && (inc || dn)) begin
        pend_d[0] = 1'b1;
        dec_d[0]  = dn;
      end
    end
    for (int b = 0; b < 3; b++)
      if (s == STG[b] && pend_q[b]) begin
        ptr_d[8*b +: 8] = dec_q[b] ? ptr_q[8*b +: 8] - 8'd1 : ptr_q[8*b +: 8] + 8'd1;
        pend_d[b]       = 1'b0;
      end
    for (int b = 0; b < 2; b++)
      if (s == STG[b] && pend_q[b] && ptr_q[8*b +: 8] == (dec_q[b] ? 8'h00 : 8'hFF)) begin
        pend_d[b+1] = 1'b1;
        dec_d[b+1]  = dec_q[b];
      end
    ptr_d = ptr_d & MSK;
  end
  always_ff @(negedge clk or negedge rst_n)
    if (!rst_n) begin
      ptr_q  <= '0;
      pend_q <= '0;
      dec_q  <= '0;
    end else begin
      ptr_q  <= ptr_d;
      pend_q <= pend_d;
      dec_q  <= dec_d;
    end
  assign ptr = ptr_q;
endmodule

// File: rtl/slinky_multi_ptr.sv
// slinky_multi_ptr: Apple II slot controller with NUM_PTR auto-stepping SRAM pointers,
// full register readback and an IOSTRB ROM bank register.
module slinky_multi_ptr
  import slinky_pkg::*;
#(
  parameter int ADDR_W  = 24,
  parameter int NUM_PTR = 2,
  parameter int BANK_W  = 8
) (
  input  logic              C7M,
  input  logic              nRES,
  input  logic              PHI1,
  input  logic              nDEVSEL,
  input  logic              nIOSEL,
  input  logic              nIOSTRB,
  input  logic [10:0]       A,
  input  logic              nWE,
  input  logic [7:0]        Din,
  output logic [7:0]        Dout,
  output logic              DOE,
  output logic              RDOE,
  output logic [ADDR_W-1:0] RA,
  output logic              RAMCS,
  output logic              nROMCS
);
  logic [2:0]           s_q, s_d;
  logic                 phi1_q, phi1_d, phi0_seen_q, phi0_seen_d;
  logic                 dben_q, dben_d, csen_q, csen_d;
  logic                 regen_q, regen_d, ioromen_q, ioromen_d;
  logic [2*NUM_PTR-1:0] mode_q, mode_d;
  logic [BANK_W-1:0]    bank_q, bank_d;
  logic [1:0]           act_q, act_d;
  logic [1:0]           p, off;
  logic                 dev, dp, wr, at_wr, rom_on, io_bus;
  logic [23:0]          ptr [4];
  logic [31:0]          rd_word;
  logic [ADDR_W-1:0]    ptr_ra;
  assign p   = A[3:2];
  assign off = A[1:0];
  always_comb begin
    dev         = !nDEVSEL && regen_q;
    dp          = dev && off == OFF_DATA && int'(p) < NUM_PTR;
    at_wr       = s_q == S_WRITE;
    wr          = dev && !nWE && at_wr;
    rom_on      = !nIOSTRB && ioromen_q;
    io_bus      = s_q == S_BUS && !nIOSEL;
    s_d         = (PHI1 && !phi1_q && phi0_seen_q) ? S_SYNC :
                  (s_q == 3'd0 || s_q == S_LATE) ? s_q : s_q + 3'd1;
    phi1_d      = PHI1;
    phi0_seen_d = phi0_seen_q || !PHI1;
    dben_d      = s_q >= S_BUS;
    csen_d      = (s_q == S_BUS && nWE) || s_q >= S_CS;
    regen_d     = regen_q || io_bus;
    ioromen_d   = (s_q == S_BUS && !nIOSTRB && A == 11'h7FF) ? 1'b0 : ioromen_q || io_bus;
    mode_d      = (wr && A[3:0] == REG_MODE) ? Din[2*NUM_PTR-1:0] : mode_q;
    bank_d      = (wr && A[3:0] == REG_BANK) ? Din[BANK_W-1:0] : bank_q;
    act_d       = (dp && at_wr) ? p : act_q;
    // absent pointers and the data-port slot read as zero through the padded word
    rd_word     = {8'h00, ptr[p]};
    Dout        = A[3:0] == REG_MODE ? 8'(mode_q) :
                  A[3:0] == REG_BANK ? 8'(bank_q) : rd_word[8*off +: 8];
    ptr_ra      = ptr[dp ? p : act_q][ADDR_W-1:0];
    RA          = !nIOSTRB ? ((ADDR_W'(bank_q) + ADDR_W'(1)) << 11) | ADDR_W'(A) :
                  !nIOSEL  ? ADDR_W'(A) : ptr_ra;
    RAMCS       = dp && csen_q;
    nROMCS      = !(csen_q && (!nIOSEL || rom_on));
    DOE         = dben_q && nWE && (dev || !nIOSEL || rom_on);
    RDOE        = dben_q && !nWE;
  end
  for (genvar i = 0; i < 4; i++) begin : g_ptr
    if (i < NUM_PTR) begin : g_on
      slinky_ptr #(.ADDR_W(ADDR_W)) u_ptr (
        .clk   (C7M),
        .rst_n (nRES),
        .s     (s_q),
        .wr_en ((wr && p == 2'(i)) ? {off == OFF_HI, off == OFF_MID, off == OFF_LO} : 3'b000),
        .step  (dp && p == 2'(i)),
        .din   (Din),
        .mode  (mode_q[2*i +: 2]),
        .ptr   (ptr[i])
      );
    end else begin : g_off
      assign ptr[i] = '0;
    end
  end
  always_ff @(posedge C7M or negedge nRES)
    if (!nRES) begin
      s_q         <= '0;
      phi1_q      <= 1'b0;
      phi0_seen_q <= 1'b0;
      dben_q      <= 1'b0;
      csen_q      <= 1'b0;
      regen_q     <= 1'b0;
      ioromen_q   <= 1'b0;
    end else begin
      s_q         <= s_d;
      phi1_q      <= phi1_d;
      phi0_seen_q <= phi0_seen_d;
      dben_q      <= dben_d;
      csen_q      <= csen_d;
      regen_q     <= regen_d;
      ioromen_q   <= ioromen_d;
    end
  always_ff @(negedge C7M or negedge nRES)
    if (!nRES) begin
      mode_q <= '0;
      bank_q <= '0;
      act_q  <= '0;
    end else begin
      mode_q <= mode_d;
      bank_q <= bank_d;
      act_q  <= act_d;
    end
endmodule
